weight_line_loader: RTL and testbench
=====================================

Name: weight_line_loader

Overview:
- Downstream consumer of the serial-to-parallel deserializer in the accelerator fetch path.
- Gates the deserializer enable, captures each completed FETCH_WIDTH word on its one-cycle valid pulse, and packs WORDS_PER_LINE words into one line.
- Writes each packed line to the on-chip weight SRAM at an auto-incrementing address, starting at a programmed base, for a programmed number of lines.
- Signals completion with a done pulse.

Parameters:
- FETCH_WIDTH, 16, width of each word from the deserializer.
- WORDS_PER_LINE, 4, words packed per SRAM line; power of 2, >= 2.
- ADDR_WIDTH, 8, SRAM address width; also the width of the line-count port.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first SRAM line address; sampled on accepted start.
- num_lines  in  ADDR_WIDTH  number of lines to load; sampled on accepted start.
- in_data  in  FETCH_WIDTH  deserializer parallel word.
- in_valid  in  1  one-cycle pulse; in_data is valid only in this cycle.
- deser_en  out  1  enable to the deserializer; high only in LOAD.
- mem_we  out  1  SRAM write strobe, one cycle per line.
- mem_addr  out  ADDR_WIDTH  SRAM write address.
- mem_wdata  out  FETCH_WIDTH*WORDS_PER_LINE  packed line.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse at the end of a load.
- err_overrun  out  1  sticky flag: a word arrived outside LOAD.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Word counter, line counter, address register and pack register all 0.
- Reset asserted mid-load aborts immediately. No further mem_we. done is not pulsed.
- States:
  - IDLE:
    - start=1 and num_lines!=0: latch base_addr and num_lines, clear counters, go to LOAD.
    - start=1 and num_lines==0: no transition; done=1 next cycle, no writes.
  - LOAD:
    - deser_en=1, busy=1.
    - start is ignored.
  - After the last line completes: return to IDLE.
- Capture: in LOAD, each cycle with in_valid=1 stores in_data into slot word_cnt of the pack register. Slot k occupies bits [k*FETCH_WIDTH +: FETCH_WIDTH]; word 0 is the LSBs. word_cnt then increments and wraps at WORDS_PER_LINE.
- Line write: when the word captured at cycle t fills slot WORDS_PER_LINE-1, the following hold at cycle t+1:
  - mem_we=1.
  - mem_wdata = the full line.
  - mem_addr = base_addr + line_cnt, modulo 2^ADDR_WIDTH; wraps silently.
  - line_cnt increments.
- mem_we is high for exactly one cycle per line. mem_addr and mem_wdata hold their last values when mem_we=0.
- Back-to-back in_valid on consecutive cycles is legal; no backpressure exists, so the loader never stalls.
- Completion: if the line written at t+1 is line num_lines-1, then in cycle t+1:
  - done=1.
  - busy=0.
  - deser_en=0.
  - FSM in IDLE.
  - done and the final mem_we coincide.
- A start in the same cycle as done is accepted: the FSM is already in IDLE in that cycle.
- Partial line: no partial write is ever issued. Words beyond the final line cannot arrive, because deser_en drops.
- Overrun: in_valid=1 while not in LOAD sets err_overrun and discards the word. err_overrun is cleared only by an accepted start or by reset.

Optional Feature:
- Macro: WEIGHT_LINE_LOADER_CHECKSUM_EN.
- Defined:
  - Extra output port checksum, FETCH_WIDTH bits: running sum modulo 2^FETCH_WIDTH of every word captured in LOAD.
  - Cleared to 0 on an accepted start and on reset.
  - Stable and valid from the done cycle until the next accepted start.
- Undefined: the checksum port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic load, FETCH_WIDTH=16, WPL=4:
  - Stimulus: start, base_addr=0x10, num_lines=2, then 8 in_valid words 0x0001..0x0008 spaced 16 cycles apart.
  - Response: mem_we at addr 0x10 with wdata 0x0004_0003_0002_0001; mem_we at addr 0x11 with wdata 0x0008_0007_0006_0005. done coincides with the second mem_we. deser_en falls in that same cycle.
- Back-to-back words:
  - Stimulus: 4 consecutive in_valid cycles of 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD.
  - Response: a single mem_we one cycle after the 4th word, wdata 0xDDDD_CCCC_BBBB_AAAA.
- Zero length:
  - Stimulus: start with num_lines=0.
  - Response: done=1 next cycle. No mem_we. busy and deser_en stay 0.
- Address wrap:
  - Stimulus: base_addr=0xFF, num_lines=2.
  - Response: writes to 0xFF then 0x00.
- Reset and overrun:
  - Reset after 2 words of line 0: all outputs 0, no mem_we, no done.
  - in_valid in IDLE: err_overrun=1 and stays 1. The next start clears it.
- Checksum (macro defined):
  - Stimulus: words 0x0001..0x0008.
  - Response: checksum=0x0024 at done.
  - Stimulus: four words of 0xFFFF.
  - Response: checksum=0xFFFC.

Source files
------------

// File: rtl/weight_line_loader_if.sv
// Bundles the loader's control, deserializer-side and SRAM-side signals.
// The optional checksum signal exists only when WEIGHT_LINE_LOADER_CHECKSUM_EN is defined.
interface weight_line_loader_if #(
    parameter int FETCH_WIDTH    = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 8
);
    logic                                  start;
    logic [ADDR_WIDTH-1:0]                 base_addr;
    logic [ADDR_WIDTH-1:0]                 num_lines;
    logic [FETCH_WIDTH-1:0]                in_data;
    logic                                  in_valid;
    logic                                  deser_en;
    logic                                  mem_we;
    logic [ADDR_WIDTH-1:0]                 mem_addr;
    logic [FETCH_WIDTH*WORDS_PER_LINE-1:0] mem_wdata;
    logic                                  busy;
    logic                                  done;
    logic                                  err_overrun;
`ifdef WEIGHT_LINE_LOADER_CHECKSUM_EN
    logic [FETCH_WIDTH-1:0]                checksum;
`endif

    modport master (
        output start, base_addr, num_lines, in_data, in_valid,
        input  deser_en, mem_we, mem_addr, mem_wdata, busy, done, err_overrun
`ifdef WEIGHT_LINE_LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  start, base_addr, num_lines, in_data, in_valid,
        output deser_en, mem_we, mem_addr, mem_wdata, busy, done, err_overrun
`ifdef WEIGHT_LINE_LOADER_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/weight_line_loader.sv
// Packs deserializer words into SRAM lines; each line is written the cycle after its last word, done with the final write.
// No backpressure: the deserializer is gated by deser_en only. Optional running checksum via WEIGHT_LINE_LOADER_CHECKSUM_EN.
module weight_line_loader #(
    parameter int FETCH_WIDTH    = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    weight_line_loader_if.slave bus
);
    localparam int WCW = $clog2(WORDS_PER_LINE);
    localparam int LW  = FETCH_WIDTH * WORDS_PER_LINE;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                state;
    logic [WCW-1:0]        word_cnt;
    logic [ADDR_WIDTH-1:0] line_cnt;
    logic [ADDR_WIDTH-1:0] addr_base;
    logic [ADDR_WIDTH-1:0] line_total;
    logic [LW-1:0]         pack;
    logic [LW-1:0]         line_full;
    logic                  deser_en_q, mem_we_q, busy_q, done_q, err_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [LW-1:0]         mem_wdata_q;
    logic [FETCH_WIDTH-1:0] cks_q;

    logic capture, last_word, last_line, take_start;

    assign capture    = (state == LOAD) && bus.in_valid;
    assign last_word  = (word_cnt == WCW'(WORDS_PER_LINE - 1));
    assign last_line  = (line_cnt == line_total - ADDR_WIDTH'(1));
    assign take_start = (state == IDLE) && bus.start;

    // Pack register with the incoming word merged in, so the completing word can go straight to the SRAM.
    always_comb begin
        line_full = pack;
        line_full[int'(word_cnt)*FETCH_WIDTH +: FETCH_WIDTH] = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            word_cnt    <= '0;
            line_cnt    <= '0;
            addr_base   <= '0;
            line_total  <= '0;
            pack        <= '0;
            deser_en_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cks_q       <= '0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_start) begin
                        err_q <= 1'b0;
                        cks_q <= '0;
                        if (bus.num_lines != '0) begin
                            state      <= LOAD;
                            addr_base  <= bus.base_addr;
                            line_total <= bus.num_lines;
                            word_cnt   <= '0;
                            line_cnt   <= '0;
                            pack       <= '0;
                            deser_en_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                    // A word outside LOAD is dropped; flag it even if a start is taken this cycle.
                    if (bus.in_valid) err_q <= 1'b1;
                end
                LOAD: begin
                    if (capture) begin
                        pack     <= line_full;
                        word_cnt <= word_cnt + WCW'(1);
                        cks_q    <= cks_q + bus.in_data;
                        if (last_word) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= line_full;
                            mem_addr_q  <= addr_base + line_cnt;
                            line_cnt    <= line_cnt + ADDR_WIDTH'(1);
                            if (last_line) begin
                                state      <= IDLE;
                                done_q     <= 1'b1;
                                busy_q     <= 1'b0;
                                deser_en_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.deser_en    = deser_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_overrun = err_q;
`ifdef WEIGHT_LINE_LOADER_CHECKSUM_EN
    assign bus.checksum    = cks_q;
`else
    logic unused_cks;
    assign unused_cks = ^cks_q;
`endif
endmodule

// File: tb/tb_weight_line_loader.sv
// Directed bench for weight_line_loader: basic load, back-to-back words, zero length, address wrap, reset abort, overrun.
module tb_weight_line_loader;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    weight_line_loader_if #(.FETCH_WIDTH(16), .WORDS_PER_LINE(4), .ADDR_WIDTH(8)) bus ();

    weight_line_loader #(.FETCH_WIDTH(16), .WORDS_PER_LINE(4), .ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) we_cnt++;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic kick(input logic [7:0] base, input logic [7:0] n);
        bus.base_addr = base;
        bus.num_lines = n;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.num_lines = '0;
        bus.in_data = '0; bus.in_valid = 1'b0;
        repeat (3) step();
        check("rst_busy", bus.busy, 0);
        check("rst_deser", bus.deser_en, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err_overrun, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        step();

        // Basic load: 8 spaced words into 0x10, 0x11
        kick(8'h10, 8'd2);
        check("t1_busy", bus.busy, 1);
        check("t1_deser", bus.deser_en, 1);
        for (int i = 1; i <= 8; i++) begin
            repeat (15) step();
            send(16'(i));
            if (i == 4) begin
                check("t1_we0", bus.mem_we, 1);
                check("t1_addr0", bus.mem_addr, 8'h10);
                check("t1_wdata0", bus.mem_wdata, 64'h0004_0003_0002_0001);
                check("t1_nodone0", bus.done, 0);
                check("t1_busy0", bus.busy, 1);
            end else if (i == 8) begin
                check("t1_we1", bus.mem_we, 1);
                check("t1_addr1", bus.mem_addr, 8'h11);
                check("t1_wdata1", bus.mem_wdata, 64'h0008_0007_0006_0005);
                check("t1_done", bus.done, 1);
                check("t1_busy_end", bus.busy, 0);
                check("t1_deser_end", bus.deser_en, 0);
`ifdef WEIGHT_LINE_LOADER_CHECKSUM_EN
                check("t1_cks", bus.checksum, 16'h0024);
`endif
            end else begin
                check("t1_we_idle", bus.mem_we, 0);
            end
        end
        step();
        check("t1_we_drop", bus.mem_we, 0);
        check("t1_done_drop", bus.done, 0);
        check("t1_addr_hold", bus.mem_addr, 8'h11);
        check("t1_wdata_hold", bus.mem_wdata, 64'h0008_0007_0006_0005);
        check("t1_we_cnt", we_cnt, 2);

        // Back-to-back words
        kick(8'h20, 8'd1);
        bus.in_valid = 1'b1;
        bus.in_data = 16'hAAAA; step();
        bus.in_data = 16'hBBBB; step();
        bus.in_data = 16'hCCCC; step();
        check("t2_we_early", bus.mem_we, 0);
        bus.in_data = 16'hDDDD; step();
        bus.in_valid = 1'b0;
        check("t2_we", bus.mem_we, 1);
        check("t2_addr", bus.mem_addr, 8'h20);
        check("t2_wdata", bus.mem_wdata, 64'hDDDD_CCCC_BBBB_AAAA);
        check("t2_done", bus.done, 1);
        step();
        check("t2_we_cnt", we_cnt, 3);
        check("t2_err", bus.err_overrun, 0);

        // Zero length
        kick(8'h50, 8'd0);
        check("t3_done", bus.done, 1);
        check("t3_busy", bus.busy, 0);
        check("t3_deser", bus.deser_en, 0);
        check("t3_we", bus.mem_we, 0);
        step();
        check("t3_done_drop", bus.done, 0);
        check("t3_busy_stay", bus.busy, 0);
        check("t3_we_cnt", we_cnt, 3);

        // Address wrap
        kick(8'hFF, 8'd2);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 16'(16'h0100 + i);
            step();
            if (i == 3) begin
                check("t4_we0", bus.mem_we, 1);
                check("t4_addr0", bus.mem_addr, 8'hFF);
            end
        end
        bus.in_valid = 1'b0;
        check("t4_we1", bus.mem_we, 1);
        check("t4_addr1", bus.mem_addr, 8'h00);
        check("t4_wdata1", bus.mem_wdata, 64'h0107_0106_0105_0104);
        check("t4_done", bus.done, 1);
        step();
        check("t4_we_cnt", we_cnt, 5);
        check("t4_no_err", bus.err_overrun, 0);

        // Reset mid-load
        kick(8'h30, 8'd1);
        send(16'h1111);
        send(16'h2222);
        rst_n = 1'b0;
        step();
        check("t5_busy", bus.busy, 0);
        check("t5_deser", bus.deser_en, 0);
        check("t5_we", bus.mem_we, 0);
        check("t5_done", bus.done, 0);
        check("t5_addr", bus.mem_addr, 0);
        check("t5_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        repeat (5) step();
        check("t5_we_cnt", we_cnt, 5);
        check("t5_done_cnt", done_cnt, 4);

        // Overrun in IDLE, cleared by the next start
        send(16'h5555);
        check("t6_err_set", bus.err_overrun, 1);
        repeat (3) step();
        check("t6_err_sticky", bus.err_overrun, 1);
        check("t6_we_cnt", we_cnt, 5);
        kick(8'h40, 8'd1);
        check("t6_err_clr", bus.err_overrun, 0);
        check("t6_busy", bus.busy, 1);
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        check("t6_we", bus.mem_we, 1);
        check("t6_addr", bus.mem_addr, 8'h40);
        check("t6_wdata", bus.mem_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t6_done", bus.done, 1);
`ifdef WEIGHT_LINE_LOADER_CHECKSUM_EN
        check("t6_cks", bus.checksum, 16'hFFFC);
        step();
        check("t6_cks_hold", bus.checksum, 16'hFFFC);
`endif
        step();
        check("t6_done_cnt", done_cnt, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
